// File: rtl/translator_out.sv
`default_nettype none
// =============================================================================
// translator_out : NoC egress word -> Avalon-ST beat, framing/ID checks, output FIFO
// Revision 1.0
// =============================================================================
module translator_out #(
   parameter int DATA_WIDTH = 512,
   parameter int WIDTH_OUT  = 600,
   parameter int NUM_VC     = 2,
   parameter int NOC_RADIX  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [WIDTH_OUT-1:0]  i_data_in,
   input  logic                  i_valid_in,
   output logic                  i_ready_out,
   input  logic                  i_payload_in,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_sop,
   output logic                  o_eop,
   output logic [5:0]            o_empty,
   output logic                  o_error,
   output logic [31:0]           o_pktid,
   input  logic                  o_ready_in,
   output logic                  o_frame_err,
   output logic                  o_seq_err,
   output logic                  o_fmt_err,
   output logic [15:0]           o_pkt_count
);

   localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int AW     = (NOC_RADIX > 1) ? $clog2(NOC_RADIX) : 1;
   localparam int FLIT_W = WIDTH_OUT / 4;
   localparam int FD_W   = FLIT_W - 3 - VCW - AW;
   localparam int SEG_W  = DATA_WIDTH / 4;
   localparam int P_W    = DATA_WIDTH + 34;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       IN_PKT   = 1'b1;
   localparam logic [1:0]       FLAGS_OK = 2'b10;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  sop;
      logic                  eop;
      logic [5:0]            empty;
      logic                  error;
      logic [31:0]           pktid;
   } beat_t;

   logic [FD_W-1:0]    fd [4];
   logic [4*FD_W-1:0]  fd_all;
   logic [P_W-1:0]     pay;
   logic [DATA_WIDTH-1:0] hdr_data;
   logic               flit3_valid;
   logic               sop;
   logic               eop;
   logic [1:0]         flags;
   logic               unused_bits;

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_flit
         assign fd[k] = i_data_in[k*FLIT_W +: FD_W];
      end
   endgenerate

   assign flit3_valid = i_data_in[WIDTH_OUT-1];
   assign sop         = i_data_in[WIDTH_OUT-2];
   assign eop         = i_data_in[FLIT_W-3];
   assign fd_all      = {fd[3], fd[2], fd[1], fd[0]};
   assign pay         = fd_all[4*FD_W-1 -: P_W];
   assign flags       = pay[P_W-1 -: 2];
   assign hdr_data    = {fd[3][FD_W-1 -: SEG_W], fd[2][FD_W-1 -: SEG_W],
                         fd[1][FD_W-1 -: SEG_W], fd[0][FD_W-1 -: SEG_W]};
   // vc/dst and spare flit bits carry no meaning on this side of the fabric
   assign unused_bits = ^i_data_in;

   beat_t new_beat;

   always_comb begin
      new_beat     = '0;
      new_beat.sop = sop;
      new_beat.eop = eop;
      if (i_payload_in) begin
         new_beat.data  = pay[DATA_WIDTH-1:0];
         new_beat.pktid = pay[DATA_WIDTH +: 32];
      end else begin
         new_beat.data  = hdr_data;
         new_beat.error = fd[3][FD_W-1-SEG_W];
         new_beat.empty = fd[3][FD_W-2-SEG_W -: 6];
      end
   end

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic             accept;
   logic             push;
   logic             pop;
   logic             frame_err_nxt;
   logic             fmt_err_nxt;
   logic             seq_err_nxt;
   logic             id_valid;
   logic [31:0]      last_id;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   beat_t            mem [FIFO_DEPTH];
   beat_t            head;

   assign accept = i_valid_in & i_ready_out & flit3_valid;

   always_comb begin
      state_nxt     = state;
      push          = 1'b0;
      frame_err_nxt = 1'b0;
      if (accept) begin
         if (sop) begin
            // a sop inside a packet abandons the old one and restarts framing
            push          = 1'b1;
            frame_err_nxt = (state == IN_PKT);
            state_nxt     = eop ? IDLE : IN_PKT;
         end else if (state == IN_PKT) begin
            push = 1'b1;
            if (eop) begin
               state_nxt = IDLE;
            end
         end else begin
            frame_err_nxt = 1'b1;
         end
      end
   end

   assign fmt_err_nxt = push & i_payload_in & (flags != FLAGS_OK);
   assign seq_err_nxt = push & sop & i_payload_in & id_valid &
                        (new_beat.pktid != last_id + 32'd1);

   assign pop     = o_valid & o_ready_in;
   assign o_valid = (count != '0);
   assign head    = mem[rd_ptr];

   always_comb begin
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= new_beat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         i_ready_out <= 1'b1;
         id_valid    <= 1'b0;
         last_id     <= '0;
         o_frame_err <= 1'b0;
         o_seq_err   <= 1'b0;
         o_fmt_err   <= 1'b0;
         o_pkt_count <= '0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         i_ready_out <= (count_nxt < DEPTH_C);
         o_frame_err <= frame_err_nxt;
         o_seq_err   <= seq_err_nxt;
         o_fmt_err   <= fmt_err_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (head.eop && (o_pkt_count != 16'hFFFF)) begin
               o_pkt_count <= o_pkt_count + 16'd1;
            end
         end
         if (push & sop & i_payload_in) begin
            last_id  <= new_beat.pktid;
            id_valid <= 1'b1;
         end
      end
   end

   assign o_data  = head.data;
   assign o_sop   = head.sop;
   assign o_eop   = head.eop;
   assign o_empty = head.empty;
   assign o_error = head.error;
   assign o_pktid = head.pktid;

endmodule
`default_nettype wire

// File: tb/tb_translator_out.sv
`default_nettype none
// tb_translator_out : randomized scoreboard bench for translator_out
// Revision 1.0
module tb_translator_out;

   logic         clk = 1'b0;
   logic         rstn;
   logic [599:0] i_data_in;
   logic         i_valid_in;
   logic         i_ready_out;
   logic         i_payload_in;
   logic [511:0] o_data;
   logic         o_valid;
   logic         o_sop;
   logic         o_eop;
   logic [5:0]   o_empty;
   logic         o_error;
   logic [31:0]  o_pktid;
   logic         o_ready_in;
   logic         o_frame_err;
   logic         o_seq_err;
   logic         o_fmt_err;
   logic [15:0]  o_pkt_count;

   translator_out dut (
      .clk(clk), .rstn(rstn), .i_data_in(i_data_in), .i_valid_in(i_valid_in),
      .i_ready_out(i_ready_out), .i_payload_in(i_payload_in), .o_data(o_data),
      .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_empty(o_empty),
      .o_error(o_error), .o_pktid(o_pktid), .o_ready_in(o_ready_in),
      .o_frame_err(o_frame_err), .o_seq_err(o_seq_err), .o_fmt_err(o_fmt_err),
      .o_pkt_count(o_pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           v3;
      bit           sop;
      bit           eop;
      logic [511:0] data;
      logic [5:0]   empty;
      bit           error;
      logic [31:0]  pktid;
      logic [1:0]   flags;
   } stim_t;

   typedef struct {
      logic [511:0] data;
      bit           sop;
      bit           eop;
      logic [5:0]   empty;
      bit           error;
      logic [31:0]  pktid;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   int   frame_seen = 0, seq_seen = 0, fmt_seen = 0;
   int   exp_frame = 0, exp_seq = 0, exp_fmt = 0;
   int   exp_pkts = 0;
   int   acc_cnt = 0;
   bit   m_in_pkt = 0;
   bit   m_id_valid = 0;
   logic [31:0] m_last_id = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic stim_t mk(input bit s, input bit e, input logic [31:0] id, input logic [1:0] fl);
      stim_t b;
      b.v3    = 1'b1;
      b.sop   = s;
      b.eop   = e;
      b.data  = rand512();
      b.empty = 6'($urandom_range(0, 63));
      b.error = 1'($urandom_range(0, 1));
      b.pktid = id;
      b.flags = fl;
      return b;
   endfunction

   // Pack abstract beat fields into a NoC word; spare bits are randomized.
   function automatic logic [599:0] build(input stim_t s, input bit payload);
      logic [567:0] d;
      logic [599:0] w;
      logic [31:0]  r0, r1, r2;
      r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
      if (payload)
         d = {s.flags, s.pktid, s.data, r0[21:0]};
      else
         d = {s.data[511:384], s.error, s.empty, r0[6:0],
              s.data[383:256], r0[20:7], s.data[255:128], r1[13:0],
              s.data[127:0], r1[27:14]};
      w[599:450] = {s.v3, s.sop, r2[0], r2[5:1], d[567:426]};
      w[449:300] = {r2[6], r2[7], r2[8], r2[13:9], d[425:284]};
      w[299:150] = {r2[14], r2[15], r2[16], r2[21:17], d[283:142]};
      w[149:0]   = {r2[22], r2[23], s.eop, r2[28:24], d[141:0]};
      return w;
   endfunction

   task automatic model_accept(input stim_t s, input bit payload);
      exp_t e;
      if (!s.v3) return;
      if (!m_in_pkt && !s.sop) begin
         exp_frame++;
         return;
      end
      if (m_in_pkt && s.sop) exp_frame++;
      if (payload && s.flags != 2'b10) exp_fmt++;
      if (payload && s.sop) begin
         if (m_id_valid && s.pktid != m_last_id + 32'd1) exp_seq++;
         m_last_id  = s.pktid;
         m_id_valid = 1'b1;
      end
      m_in_pkt = !s.eop;
      e.data  = s.data;
      e.sop   = s.sop;
      e.eop   = s.eop;
      e.empty = payload ? 6'd0 : s.empty;
      e.error = payload ? 1'b0 : s.error;
      e.pktid = payload ? s.pktid : 32'd0;
      q.push_back(e);
   endtask

   task automatic send(input stim_t s);
      int n;
      bit rdy;
      bit payload;
      payload    = i_payload_in;
      i_data_in  = build(s, payload);
      i_valid_in = 1'b1;
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 500) begin
         @(negedge clk);
         rdy = i_ready_out;
         @(posedge clk);
         n++;
      end
      if (rdy) begin
         acc_cnt++;
         model_accept(s, payload);
      end else begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=no_accept required=accept");
      end
      #1;
      i_valid_in = 1'b0;
   endtask

   task automatic check_phase(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check({name, "_drain"}, 64'(q.size()), 64'd0);
      repeat (3) @(negedge clk);
      check({name, "_frame_pulses"}, 64'(frame_seen), 64'(exp_frame));
      check({name, "_seq_pulses"},   64'(seq_seen),   64'(exp_seq));
      check({name, "_fmt_pulses"},   64'(fmt_seen),   64'(exp_fmt));
      check({name, "_pkt_count"},    64'(o_pkt_count), 64'(exp_pkts));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      q.delete();
      m_in_pkt   = 1'b0;
      m_id_valid = 1'b0;
      exp_pkts   = 0;
   endtask

   // Monitor: counts error pulses and scores every popped beat.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_frame_err) frame_seen++;
         if (o_seq_err)   seq_seen++;
         if (o_fmt_err)   fmt_seen++;
         if (rstn && o_valid && o_ready_in) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected actual=sop%0b_eop%0b_id%0h required=none", o_sop, o_eop, o_pktid);
            end else begin
               e = q.pop_front();
               if (o_data !== e.data || o_sop !== e.sop || o_eop !== e.eop ||
                   o_empty !== e.empty || o_error !== e.error || o_pktid !== e.pktid) begin
                  errors++;
                  $display("FAIL beat actual=%h/s%0b/e%0b/m%0d/r%0b/id%0h required=%h/s%0b/e%0b/m%0d/r%0b/id%0h",
                           o_data, o_sop, o_eop, o_empty, o_error, o_pktid,
                           e.data, e.sop, e.eop, e.empty, e.error, e.pktid);
               end
               if (e.eop && exp_pkts < 65535) exp_pkts++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t       s;
      int          acc_base;
      bit          rdone;
      logic [31:0] id;
      int          len;
      bit          abort;
      logic [1:0]  fl;

      rstn = 1'b0; i_valid_in = 1'b0; i_payload_in = 1'b0; o_ready_in = 1'b1;
      i_data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_ready", 64'(i_ready_out), 64'd1);
      check("rst_pkt_count", 64'(o_pkt_count), 64'd0);
      check("rst_pulses", 64'({o_frame_err, o_seq_err, o_fmt_err}), 64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // header format, single-beat packet with byte-ramp data
      s = mk(1, 1, 32'd0, 2'b10);
      for (int i = 0; i < 64; i++) s.data[i*8 +: 8] = 8'(i + 1);
      s.empty = 6'd5;
      s.error = 1'b1;
      send(s);
      @(negedge clk);
      check("hdr_latency_valid", 64'(o_valid), 64'd1);
      check_phase("hdr");

      // payload format, 3-beat packet id 7
      i_payload_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s = mk(k == 0, k == 2, 32'd7, 2'b10);
         s.data = {64{8'hA5}};
         send(s);
      end
      check_phase("pay3");

      // ID wrap-around then a discontinuity
      do_reset();
      send(mk(1, 1, 32'hFFFF_FFFE, 2'b10));
      send(mk(1, 1, 32'hFFFF_FFFF, 2'b10));
      send(mk(1, 1, 32'h0000_0000, 2'b10));
      check_phase("wrap");
      send(mk(1, 1, 32'h0000_0005, 2'b10));
      check_phase("jump");
      check("seq_exactly_one", 64'(seq_seen), 64'd1);

      // framing and format errors
      send(mk(0, 1, 32'd6, 2'b10));
      send(mk(1, 0, 32'd6, 2'b10));
      send(mk(1, 1, 32'd7, 2'b10));
      send(mk(1, 1, 32'd8, 2'b11));
      check_phase("errs");
      check("frame_total", 64'(frame_seen), 64'd2);
      check("fmt_total", 64'(fmt_seen), 64'd1);

      // backpressure with 6 back-to-back words
      i_payload_in = 1'b0;
      o_ready_in   = 1'b0;
      acc_base     = acc_cnt;
      fork
         begin
            for (int k = 0; k < 6; k++) send(mk(1, 1, 32'd0, 2'b10));
         end
         begin
            repeat (12) @(negedge clk);
            check("bp_accepts", 64'(acc_cnt - acc_base), 64'd4);
            check("bp_ready_low", 64'(i_ready_out), 64'd0);
            @(posedge clk);
            #1;
            o_ready_in = 1'b1;
         end
      join
      check_phase("bp");

      // reset with two beats of an open packet buffered
      o_ready_in = 1'b0;
      send(mk(1, 0, 32'd0, 2'b10));
      send(mk(0, 0, 32'd0, 2'b10));
      do_reset();
      @(negedge clk);
      check("mid_rst_valid", 64'(o_valid), 64'd0);
      check("mid_rst_ready", 64'(i_ready_out), 64'd1);
      check("mid_rst_pkt_count", 64'(o_pkt_count), 64'd0);
      @(posedge clk);
      #1;
      o_ready_in = 1'b1;
      send(mk(0, 1, 32'd0, 2'b10));
      check_phase("post_rst");
      check("post_rst_frame_total", 64'(frame_seen), 64'd3);

      // randomized payload traffic with random downstream stalls
      i_payload_in = 1'b1;
      rdone = 1'b0;
      id = 32'h1000;
      fork
         begin
            for (int p = 0; p < 30; p++) begin
               len   = $urandom_range(1, 3);
               abort = ($urandom_range(0, 9) == 0) && (len > 1);
               if ($urandom_range(0, 9) == 0) send(mk(0, 1, id, 2'b10));
               if ($urandom_range(0, 4) == 0) id = $urandom();
               else id = id + 32'd1;
               for (int k = 0; k < len; k++) begin
                  if (abort && k == len - 1) break;
                  fl = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
                  if ($urandom_range(0, 7) == 0) begin
                     s = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), id, 2'b10);
                     s.v3 = 1'b0;
                     send(s);
                  end
                  send(mk(k == 0, k == len - 1, id, fl));
               end
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1;
               o_ready_in = ($urandom_range(0, 3) != 0);
            end
         end
      join
      o_ready_in = 1'b1;
      check_phase("rand_pay");

      // randomized header traffic
      i_payload_in = 1'b0;
      for (int p = 0; p < 10; p++) begin
         len = $urandom_range(1, 3);
         for (int k = 0; k < len; k++) send(mk(k == 0, k == len - 1, 32'd0, 2'b10));
      end
      check_phase("rand_hdr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
